// File: rtl/byte_ser_pkg.sv
// Shared constants and shifter state encoding for the byte serializer.
package byte_ser_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/bit_counter.sv
// Bit position counter for the shifter; wraps to 0 after the last bit.
module bit_counter #(
  parameter int DATA_W = 8,
  parameter int CW     = $clog2(DATA_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(DATA_W - 1));

  // Count bits as they leave; a new load restarts at bit 0.
  always_ff @(posedge clk) begin
    if (!rst)                 count <= '0;
    else if (clr || (en && last)) count <= '0;
    else if (en)              count <= count + CW'(1);
  end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with one-word holding register so
// back-to-back words stream without idle bits.
module byte_serializer
  import byte_ser_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ser_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);

  shift_state_e      state_q, state_d;
  logic [DATA_W-1:0] sreg, hold_reg;
  logic              hold_full;
  logic              rdy_q;
  logic [CW-1:0]     count;
  logic              last;
  logic              active, accept, adv, last_edge;
  logic              load_new, load_hold, load;

  assign active    = (state_q == SHIFT);
  assign in_ready  = !hold_full && rdy_q;
  assign accept    = in_valid && in_ready;
  assign adv       = active && ser_en;
  assign last_edge = adv && last;
  // New word goes straight to the shifter when it is free or about to free up.
  assign load_new  = accept && (!active || last_edge);
  // in_ready is low whenever hold_full is set, so these never collide.
  assign load_hold = last_edge && hold_full;
  assign load      = load_new || load_hold;

  bit_counter #(.DATA_W(DATA_W), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (load),
    .en    (adv),
    .count (count),
    .last  (last)
  );

  // Shifter state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Shifter next state: start on any load, stop after last bit with nothing queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (last_edge && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered copy of reset so in_ready rises the cycle after release.
  always_ff @(posedge clk) begin
    rdy_q <= rst;
  end

  // Holding register: fills when the shifter is mid-word, drains on last bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else if (load_hold) begin
      hold_full <= 1'b0;
    end else if (accept && !load_new) begin
      hold_full <= 1'b1;
      hold_reg  <= in_data;
    end
  end

  // Shift register: zeros shift in, so it is empty (dout=0) once a word completes.
  always_ff @(posedge clk) begin
    if (!rst)       sreg <= '0;
    else if (load)  sreg <= load_hold ? hold_reg : in_data;
    else if (adv) begin
      if (MSB_FIRST != 0) sreg <= {sreg[DATA_W-2:0], 1'b0};
      else                sreg <= {1'b0, sreg[DATA_W-1:1]};
    end
  end

  assign dout        = (MSB_FIRST != 0) ? sreg[DATA_W-1] : sreg[0];
  assign dout_valid  = adv;
  assign frame_start = adv && (count == '0);
  assign busy        = active || hold_full;

endmodule
